apb_cmd_master: RTL
===================

// Module: apb_cmd_master
// PURPOSE
// - APB requester for the codec register slave: turns a valid/ready command stream into single APB transfers.
// - Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA.
// - Returns one response per command: read data, plus error when built with PREADY_EN.
// - Sits between the testbench/CPU-side sequencer and the 4-register slave (CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC).
// PARAMETERS
// - AMBA_WORD        32  data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
// - AMBA_ADDR_WIDTH  20  width of PADDR/cmd_addr
// - HOLD_CYCLES      2   post-ACCESS hold cycles (no-PREADY build); legal range 1..15
// - TIMEOUT_CYCLES   16  max ACCESS cycles waiting for PREADY (PREADY_EN build only); legal range >=1
// PORTS
// - clk         in   1                clock, rising edge
// - rst         in   1                reset, asynchronous, active-low
// - cmd_valid   in   1                command present
// - cmd_ready   out  1                master can accept command (combinational: 1 iff state==IDLE)
// - cmd_write   in   1                1=write, 0=read
// - cmd_addr    in   AMBA_ADDR_WIDTH  target address
// - cmd_wdata   in   AMBA_WORD        write data
// - rsp_valid   out  1                one-cycle response pulse
// - rsp_rdata   out  AMBA_WORD        captured PRDATA (reads); 0 for writes
// - rsp_err     out  1                transfer error (timeout/PSLVERR); constant 0 without PREADY_EN
// - busy        out  1                1 whenever state!=IDLE
// - PSEL        out  1                APB select
// - PENABLE     out  1                APB enable
// - PADDR       out  AMBA_ADDR_WIDTH  APB address
// - PWRITE      out  1                APB direction
// - PWDATA      out  AMBA_WORD        APB write data
// - PRDATA      in   AMBA_WORD        APB read data
// - PREADY      in   1                present only with PREADY_EN
// - PSLVERR     in   1                present only with PREADY_EN
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE.
//   - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, busy all 0.
//   - In-flight transfer is dropped; no response is issued for it.
// - Command capture: a command is accepted on a rising edge with cmd_valid&&cmd_ready.
//   - cmd_write/addr/wdata are registered at acceptance into PWRITE/PADDR/PWDATA.
//   - These are held stable until the state returns to IDLE.
// - FSM, no-PREADY build:
//   - IDLE: on accept -> SETUP.
//   - SETUP: PSEL=1, PENABLE=0 for 1 cycle -> ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1 for exactly 1 cycle -> HOLD.
//   - HOLD: PSEL=1, PENABLE=0 for HOLD_CYCLES cycles (hold counter).
//     - Last HOLD cycle: PRDATA sampled into rsp_rdata (reads only); rsp_valid=1 during the next cycle; -> IDLE.
//   - PENABLE must never be high for more than 1 consecutive cycle: the slave re-triggers on PSEL&&PENABLE.
//   - HOLD covers the slave's one-cycle commit latency plus its registered PRDATA.
// - Latency, no-PREADY build, HOLD_CYCLES=2: accept edge at cycle 0.
//   - SETUP=c1, ACCESS=c2, HOLD=c3,c4, rsp_valid=c5, cmd_ready=1 again in c5.
//   - Max throughput: one command per HOLD_CYCLES+3 cycles.
// - rsp_valid is a 1-cycle pulse, asserted in the cycle the FSM is back in IDLE.
//   - rsp_rdata/rsp_err are held until the next response.
//   - A command accepted in that same cycle is legal (back-to-back).
// - Write responses: rsp_rdata=0. PRDATA is ignored for writes.
// - cmd_* changes while busy are ignored; cmd_valid held high while busy is not accepted.
// - PADDR passes through unmodified; no alignment check.
// CONFIGURATION
// - PREADY_EN undefined:
//   - PREADY/PSLVERR ports absent; HOLD state and HOLD_CYCLES used; rsp_err tied 0.
// - PREADY_EN defined (APB3 mode):
//   - HOLD state removed.
//   - ACCESS holds PSEL=PENABLE=1 until PREADY=1.
//   - On the PREADY edge: PRDATA->rsp_rdata (reads) and PSLVERR->rsp_err; -> IDLE.
//   - If PREADY stays 0 for TIMEOUT_CYCLES ACCESS cycles: terminate, rsp_err=1, rsp_rdata=0; -> IDLE.
//   - Zero-wait-state latency: accept c0, SETUP c1, ACCESS c2, rsp_valid c3.
// TESTING
// - Write then read, no PREADY_EN, against the codec slave:
//   - wr 0x4 data 0xDEADBEEF, then rd 0x4 -> rsp_rdata=0xDEADBEEF; rsp_valid exactly at c5 of each command.
// - CTRL write 0x00000002 to 0x0 -> slave start pulses exactly once; PENABLE high exactly 1 cycle per transfer.
// - Back-to-back: 4 commands with cmd_valid held 1 (writes to 0x0,0x4,0x8,0xC), then 4 reads.
//   - Reads return the written values in order; 4 rsp_valid pulses spaced 5 cycles.
// - Reset mid-transfer: drop rst during ACCESS.
//   - All outputs 0 immediately; no rsp_valid; next command after release completes normally.
// - PREADY_EN, PREADY delayed 3 cycles: PENABLE high 4 cycles; rd returns PRDATA sampled on the PREADY edge; rsp_err=PSLVERR.
// - PREADY_EN, PREADY stuck 0, TIMEOUT_CYCLES=16:
//   - Response after exactly 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; PSEL/PENABLE drop to 0.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB requester: converts a valid/ready command stream into single APB transfers
// and returns one response per command.
//
// Build option: define PREADY_EN for APB3 mode. This adds the PREADY/PSLVERR ports,
// removes the fixed HOLD phase, waits in ACCESS for PREADY (bounded by TIMEOUT_CYCLES)
// and reports transfer errors on rsp_err. Without PREADY_EN the transfer length is
// fixed (SETUP, one ACCESS cycle, HOLD_CYCLES hold cycles) and rsp_err is tied low.
module apb_cmd_master #(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  // command stream
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  // response
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  // APB requester side
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
`ifdef PREADY_EN
  input  logic                       PREADY,
  input  logic                       PSLVERR,
`endif
  input  logic [AMBA_WORD-1:0]       PRDATA
);

  // One down/up counter serves both the HOLD phase and the PREADY timeout, so it is
  // sized for whichever bound is larger.
  localparam int unsigned CntMax = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                  : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold
  } state_e;

  state_e                     state_q, state_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
`ifdef PREADY_EN
  logic                       rsp_err_q, rsp_err_d;
`endif

  // Handshake and status are decoded straight from the state register.
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef PREADY_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  // Next-state and registered-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef PREADY_EN
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Command fields are captured only here; they stay frozen until back in IDLE.
        if (cmd_valid) begin
          state_d   = StSetup;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end

      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

`ifdef PREADY_EN
      StAccess: begin
        if (PREADY) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Slave never answered: abandon the transfer and flag it.
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`else
      StAccess: begin
        // PENABLE is dropped after one cycle: the slave acts on every PSEL&&PENABLE cycle.
        state_d   = StHold;
        penable_d = 1'b0;
        cnt_d     = CntW'(HOLD_CYCLES - 1);
      end

      StHold: begin
        // Hold PSEL while the slave commits and its registered PRDATA settles.
        if (cnt_q == '0) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif

      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and all registered outputs; reset drops any transfer in flight silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef PREADY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef PREADY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

endmodule
